// File: rtl/key_debounce_array.sv
// Debouncer for an array of independent mechanical keys.
// Each channel synchronises its raw input and normalises it so that 1 means
// pressed. A stability counter then requires the changed level to persist for
// STABLE_COUNT qualifying ticks before the debounced level follows.
// Single-cycle press/release pulses and an optional long-press pulse are
// produced from the debounced level.
module key_debounce_array #(
   parameter int CHANNELS     = 4,
   parameter int CNT_WIDTH    = 16,
   parameter int STABLE_COUNT = 20,
   parameter int LONG_COUNT   = 0,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                iClock,
   input  logic                iReset,
   input  logic                iTick,
   input  logic [CHANNELS-1:0] iKey,
   output logic [CHANNELS-1:0] oKey,
   output logic [CHANNELS-1:0] oPress,
   output logic [CHANNELS-1:0] oRelease,
   output logic [CHANNELS-1:0] oLong
);

   // Input level of a key that is not being pressed; the synchroniser is
   // reset to this so that reset never looks like a press.
   localparam logic [CHANNELS-1:0] ReleasedLevel =
      (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

   // Counter value on which the next qualifying tick commits the new level.
   localparam logic [CNT_WIDTH-1:0] StableLast = CNT_WIDTH'(STABLE_COUNT - 1);

   // Hold counter saturation point and the value one tick before it.
   localparam logic [CNT_WIDTH-1:0] LongLimit = CNT_WIDTH'(LONG_COUNT);
   localparam logic [CNT_WIDTH-1:0] LongLast  =
      CNT_WIDTH'((LONG_COUNT > 0) ? (LONG_COUNT - 1) : 0);

   logic [CHANNELS-1:0]  sync1_q;
   logic [CHANNELS-1:0]  sync2_q;
   logic [CHANNELS-1:0]  raw;

   logic [CNT_WIDTH-1:0] stabCnt_q [CHANNELS];
   logic [CNT_WIDTH-1:0] stabCnt_d [CHANNELS];
   logic [CNT_WIDTH-1:0] holdCnt_q [CHANNELS];
   logic [CNT_WIDTH-1:0] holdCnt_d [CHANNELS];

   logic [CHANNELS-1:0]  key_q;
   logic [CHANNELS-1:0]  key_d;
   logic [CHANNELS-1:0]  press_q;
   logic [CHANNELS-1:0]  press_d;
   logic [CHANNELS-1:0]  release_q;
   logic [CHANNELS-1:0]  release_d;
   logic [CHANNELS-1:0]  long_q;
   logic [CHANNELS-1:0]  long_d;

   // Two-flop synchroniser bringing the asynchronous key levels into iClock.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         sync1_q <= ReleasedLevel;
         sync2_q <= ReleasedLevel;
      end else begin
         sync1_q <= iKey;
         sync2_q <= sync1_q;
      end
   end

   // Polarity normalisation so that raw=1 always means pressed.
   always_comb begin
      raw = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
   end

   // Per-channel debounce and hold-time next-state logic.
   always_comb begin
      key_d     = key_q;
      press_d   = '0;
      release_d = '0;
      long_d    = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         stabCnt_d[ch] = stabCnt_q[ch];
         holdCnt_d[ch] = holdCnt_q[ch];

         if (raw[ch] == key_q[ch]) begin
            stabCnt_d[ch] = '0;
         end else if (iTick) begin
            if (stabCnt_q[ch] >= StableLast) begin
               key_d[ch]     = raw[ch];
               stabCnt_d[ch] = '0;
               press_d[ch]   = raw[ch];
               release_d[ch] = ~raw[ch];
            end else begin
               stabCnt_d[ch] = stabCnt_q[ch] + 1'b1;
            end
         end

         if ((LONG_COUNT == 0) || !key_q[ch]) begin
            holdCnt_d[ch] = '0;
         end else if (iTick && (holdCnt_q[ch] < LongLimit)) begin
            holdCnt_d[ch] = holdCnt_q[ch] + 1'b1;
            long_d[ch]    = (holdCnt_q[ch] == LongLast);
         end
      end
   end

   // Debounce state, counters and registered pulse outputs.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         key_q     <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            stabCnt_q[ch] <= '0;
            holdCnt_q[ch] <= '0;
         end
      end else begin
         key_q     <= key_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            stabCnt_q[ch] <= stabCnt_d[ch];
            holdCnt_q[ch] <= holdCnt_d[ch];
         end
      end
   end

   // Output drive straight from the registers.
   always_comb begin
      oKey     = key_q;
      oPress   = press_q;
      oRelease = release_q;
      oLong    = long_q;
   end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed testbench for key_debounce_array with 4 channels, STABLE_COUNT=4,
// LONG_COUNT=8 and active-low keys. Expected values are hand-derived edge by
// edge relative to the moment the stimulus is applied.
module tb_key_debounce_array;

   logic       iClock;
   logic       iReset;
   logic       iTick;
   logic [3:0] iKey;
   logic [3:0] oKey;
   logic [3:0] oPress;
   logic [3:0] oRelease;
   logic [3:0] oLong;

   int checkCount;
   int errorCount;

   key_debounce_array #(
      .CHANNELS    (4),
      .CNT_WIDTH   (16),
      .STABLE_COUNT(4),
      .LONG_COUNT  (8),
      .ACTIVE_LOW  (1)
   ) dut (
      .iClock  (iClock),
      .iReset  (iReset),
      .iTick   (iTick),
      .iKey    (iKey),
      .oKey    (oKey),
      .oPress  (oPress),
      .oRelease(oRelease),
      .oLong   (oLong)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      iClock = 1'b0;
      forever #5 iClock = ~iClock;
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its expectation and count it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive the raw key levels (active-low: 0 = pressed).
   task automatic applyStimulus(input logic [3:0] keys);
      iKey = keys;
   endtask

   // Set iTick for the coming edge, advance one edge, then check all outputs.
   task automatic runEdge(input string tag, input logic tick,
                          input logic [3:0] expKey, input logic [3:0] expPress,
                          input logic [3:0] expRel, input logic [3:0] expLong);
      iTick = tick;
      @(posedge iClock);
      #1;
      checkOutput({tag, " oKey"},     {28'd0, oKey},     {28'd0, expKey});
      checkOutput({tag, " oPress"},   {28'd0, oPress},   {28'd0, expPress});
      checkOutput({tag, " oRelease"}, {28'd0, oRelease}, {28'd0, expRel});
      checkOutput({tag, " oLong"},    {28'd0, oLong},    {28'd0, expLong});
   endtask

   // Apply a press pattern and expect qualification on the 6th edge.
   task automatic pressAndQualify(input string tag, input logic [3:0] keys,
                                  input logic [3:0] mask, input logic [3:0] heldKey);
      applyStimulus(keys);
      for (int e = 1; e <= 7; e++) begin
         runEdge($sformatf("%s e%0d", tag, e), 1'b1,
                 (e >= 6) ? (heldKey | mask) : heldKey,
                 (e == 6) ? mask : 4'h0, 4'h0, 4'h0);
      end
   endtask

   // Release every key and expect the release pulse on the 6th edge.
   task automatic releaseAll(input string tag, input logic [3:0] mask);
      applyStimulus(4'hF);
      for (int e = 1; e <= 7; e++) begin
         runEdge($sformatf("%s e%0d", tag, e), 1'b1,
                 (e >= 6) ? 4'h0 : mask, 4'h0,
                 (e == 6) ? mask : 4'h0, 4'h0);
      end
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      iReset     = 1'b1;
      iTick      = 1'b1;
      iKey       = 4'hF;

      // Reset state.
      #1;
      checkOutput("reset oKey", {28'd0, oKey}, 32'h0);
      checkOutput("reset oPress", {28'd0, oPress}, 32'h0);
      @(posedge iClock);
      @(posedge iClock);
      #1;
      iReset = 1'b0;
      for (int e = 1; e <= 3; e++) runEdge($sformatf("idle e%0d", e), 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);

      // Channel 0 press, qualified on the 6th edge, then released.
      pressAndQualify("ch0 press", 4'b1110, 4'b0001, 4'b0000);
      releaseAll("ch0 release", 4'b0001);

      // Channel 1 bounce: 3 cycles pressed, 1 released, five times.
      for (int r = 0; r < 5; r++) begin
         applyStimulus(4'b1101);
         for (int e = 0; e < 3; e++) runEdge($sformatf("bounce r%0d p%0d", r, e), 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
         applyStimulus(4'hF);
         runEdge($sformatf("bounce r%0d gap", r), 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
      end
      for (int e = 1; e <= 6; e++) runEdge($sformatf("bounce tail e%0d", e), 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);

      // Channel 2 long press: oKey at edge 6, oLong at 14, release at 20 -> oRelease at 26.
      applyStimulus(4'b1011);
      for (int e = 1; e <= 27; e++) begin
         runEdge($sformatf("long e%0d", e), 1'b1,
                 (e >= 6 && e <= 25) ? 4'b0100 : 4'h0,
                 (e == 6) ? 4'b0100 : 4'h0,
                 (e == 26) ? 4'b0100 : 4'h0,
                 (e == 14) ? 4'b0100 : 4'h0);
         if (e == 20) applyStimulus(4'hF);
      end

      // Channel 3 with iTick every 3rd cycle: ticks at edges 3,6,9,12 -> rises at 12.
      applyStimulus(4'b0111);
      for (int e = 1; e <= 13; e++) begin
         runEdge($sformatf("tick e%0d", e), ((e % 3) == 0),
                 (e >= 12) ? 4'b1000 : 4'h0,
                 (e == 12) ? 4'b1000 : 4'h0, 4'h0, 4'h0);
      end
      releaseAll("ch3 release", 4'b1000);

      // Reset while ch1 is debounced-pressed and ch0 counter is at 3.
      pressAndQualify("ch1 press", 4'b1101, 4'b0010, 4'b0000);
      applyStimulus(4'b1100);
      for (int e = 1; e <= 5; e++) runEdge($sformatf("ch0 count e%0d", e), 1'b1, 4'b0010, 4'h0, 4'h0, 4'h0);
      iReset = 1'b1;
      #1;
      checkOutput("rst async oKey", {28'd0, oKey}, 32'h0);
      checkOutput("rst async oRelease", {28'd0, oRelease}, 32'h0);
      checkOutput("rst async oPress", {28'd0, oPress}, 32'h0);
      @(posedge iClock);
      #1;
      checkOutput("rst held oKey", {28'd0, oKey}, 32'h0);
      checkOutput("rst held oRelease", {28'd0, oRelease}, 32'h0);
      iReset = 1'b0;
      pressAndQualify("post rst", 4'b1100, 4'b0011, 4'b0000);
      releaseAll("post rst release", 4'b0011);

      // All four channels pressed together.
      pressAndQualify("all press", 4'b0000, 4'hF, 4'h0);
      releaseAll("all release", 4'hF);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent key channels, range 1..32.
REQ-002 Parameter CNT_WIDTH, default 16: width of the per-channel stability and hold counters.
REQ-003 Parameter STABLE_COUNT, default 20: number of consecutive qualifying ticks a changed level must persist before oKey follows, range 1..2^CNT_WIDTH-1.
REQ-004 Parameter LONG_COUNT, default 0: ticks of continuous debounced press before oLong pulses; 0 disables long-press detection.
REQ-005 Parameter ACTIVE_LOW, default 1: 1 means a key reads 0 when pressed; 0 means a key reads 1 when pressed.
REQ-006 iClock  input  1  system clock; all state updates on its rising edge.
REQ-007 iReset  input  1  reset, asynchronous, active-high.
REQ-008 iTick  input  1  sample enable; counters advance only in cycles where iTick=1.
REQ-009 iKey  input  CHANNELS  raw, asynchronous key levels, one bit per channel.
REQ-010 oKey  output  CHANNELS  debounced level per channel; 1 = pressed, regardless of ACTIVE_LOW.
REQ-011 oPress  output  CHANNELS  one-cycle pulse per channel when oKey rises.
REQ-012 oRelease  output  CHANNELS  one-cycle pulse per channel when oKey falls.
REQ-013 oLong  output  CHANNELS  one-cycle pulse per channel when a press reaches LONG_COUNT ticks.

Function
REQ-014 Each iKey bit SHALL pass through a 2-flop synchroniser; the synchronised bit SHALL then be polarity-normalised (inverted when ACTIVE_LOW=1), giving raw=1 for pressed.
REQ-015 Channels SHALL be fully independent; there is no cross-channel state or priority.
REQ-016 When raw equals oKey, the stability counter SHALL be cleared to 0 on that edge, whatever iTick is.
REQ-017 When raw differs from oKey and iTick=1 and the counter is below STABLE_COUNT-1, the counter SHALL increment by 1.
REQ-018 When raw differs from oKey and iTick=1 and the counter equals STABLE_COUNT-1, oKey SHALL take raw and the counter SHALL clear to 0 on the same edge.
REQ-019 When raw differs from oKey and iTick=0, the counter SHALL hold.
REQ-020 Any return of raw to the oKey level before qualification SHALL discard accumulated count, so a glitch shorter than STABLE_COUNT ticks never changes oKey.
REQ-021 With iTick tied 1, oKey SHALL change exactly STABLE_COUNT+2 rising edges after a clean iKey transition: 2 edges of synchroniser and STABLE_COUNT edges of counting.
REQ-022 oPress and oRelease SHALL be registered, and SHALL be high for exactly the one cycle in which oKey first shows its new value.
REQ-023 The hold counter SHALL clear while oKey=0, and SHALL increment on iTick while oKey=1, saturating at LONG_COUNT.
REQ-024 oLong SHALL pulse for one cycle on the edge where the hold counter reaches LONG_COUNT, at most once per press.
REQ-025 When LONG_COUNT=0, oLong SHALL be constant 0.
REQ-026 A release before LONG_COUNT SHALL produce oRelease only; no oLong is produced.
REQ-027 Counters SHALL never wrap.

Reset
REQ-028 iReset=1 SHALL immediately force all outputs and all counters to 0.
REQ-029 iReset=1 SHALL immediately force the synchroniser flops to the released (unpressed) input level.
REQ-030 Reset mid-count or mid-press SHALL discard all progress; no pulse is produced on reset assertion or deassertion.
REQ-031 After release, a key held pressed through reset SHALL be re-qualified normally: oKey=1 after STABLE_COUNT+2 edges, with an oPress pulse.

Verification (CHANNELS=4, STABLE_COUNT=4, LONG_COUNT=8, ACTIVE_LOW=1, iTick=1 unless stated)
REQ-032 Stimulus: iKey[0] driven 1->0 and held. Required: oKey[0]=1 on the 6th edge, oPress[0]=1 on that edge only, other channels 0.
REQ-033 Stimulus: bounce on iKey[1] of 0 for 3 cycles, 1 for 1 cycle, repeated 5 times, then 1. Required: oKey[1] stays 0, no pulses.
REQ-034 Stimulus: press ch2 held for 20 cycles, then released. Required: oLong[2] pulses once, 8 edges after oKey[2] rose; oRelease[2] pulses 6 edges after release.
REQ-035 Stimulus: iTick pulsed 1 in every 3rd cycle while ch3 pressed. Required: oKey[3] rises on the edge of the 4th tick after the synchroniser shows the press.
REQ-036 Stimulus: iReset pulsed while ch0 counter=3 and ch1 oKey=1, keys still pressed. Required: all outputs 0 at once, no oRelease; both channels re-assert with oPress 6 edges after release.
REQ-037 Stimulus: all 4 channels pressed on the same cycle. Required: simultaneous oKey=4'hF and oPress=4'hF for one cycle.
